axi_sram_slave: RTL and testbench

- AXI3-subset slave (responder) backed by a word-addressed on-chip memory array.
- Serves as the far end of the cache-to-AXI bridge in SoC simulation and standalone bridge benches.
- Accepts single-beat and 4-beat INCR bursts from the bridge, which issues arlen/awlen of 0 or 3.
- Read and write channels run independent state machines; there is no arbitration between them.

---
 rtl/axi_sram_slave.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3-subset responder backed by a word-addressed on-chip
// memory of 2^MEM_AW 32-bit words. Read and write channels each run their own
// FSM and share only the memory array. Supports single-beat and short INCR /
// FIXED bursts (WRAP is handled as INCR). Out-of-range start addresses answer
// with SLVERR and never touch memory.
//
// Optional build macro AXI_SLV_DELAY_EN: when defined, a 16-bit LFSR
// (x^16+x^14+x^13+x^11+1, seed 16'hACE1) throttles arready, awready, wready
// and the assertion of rvalid/bvalid to model a slow slave. Data and response
// values are identical either way; only latency changes.

module axi_sram_slave #(
   parameter int MEM_AW = 10,
   parameter int ID_W   = 4
) (
   input  logic            aclk,
   input  logic            areset,
   // read address channel
   input  logic [ID_W-1:0] arid,
   input  logic [31:0]     araddr,
   input  logic [7:0]      arlen,
   input  logic [2:0]      arsize,
   input  logic [1:0]      arburst,
   input  logic            arvalid,
   output logic            arready,
   // read data channel
   output logic [ID_W-1:0] rid,
   output logic [31:0]     rdata,
   output logic [1:0]      rresp,
   output logic            rlast,
   output logic            rvalid,
   input  logic            rready,
   // write address channel
   input  logic [ID_W-1:0] awid,
   input  logic [31:0]     awaddr,
   input  logic [7:0]      awlen,
   input  logic [2:0]      awsize,
   input  logic [1:0]      awburst,
   input  logic            awvalid,
   output logic            awready,
   // write data channel
   input  logic [ID_W-1:0] wid,
   input  logic [31:0]     wdata,
   input  logic [3:0]      wstrb,
   input  logic            wlast,
   input  logic            wvalid,
   output logic            wready,
   // write response channel
   output logic [ID_W-1:0] bid,
   output logic [1:0]      bresp,
   output logic            bvalid,
   input  logic            bready
);

   localparam int         DEPTH       = 1 << MEM_AW;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_t;

   // Beat size is always treated as a full word, the write ID is not used for
   // reordering, and the byte offset inside a word has no meaning here.
   logic unused_inputs;
   assign unused_inputs = ^{arsize, awsize, wid, araddr[1:0], awaddr[1:0]};

   logic [31:0] mem_q [DEPTH];

   // ------------------------------------------------------------------
   // Handshake gating: all-ones for zero-wait, LFSR bits for the slow model
   // ------------------------------------------------------------------
   logic gate_ar;
   logic gate_aw;
   logic gate_w;
   logic gate_r;
   logic gate_b;

`ifdef AXI_SLV_DELAY_EN
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Fibonacci shift toward the MSB; taps 16,14,13,11 feed the new LSB.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // The LFSR free-runs every cycle, restarting from its seed on reset.
   always_ff @(posedge aclk) begin
      if (areset) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign gate_ar = lfsr_q[0];
   assign gate_aw = lfsr_q[3];
   assign gate_w  = lfsr_q[5];
   assign gate_r  = lfsr_q[7];
   assign gate_b  = lfsr_q[9];
`else
   assign gate_ar = 1'b1;
   assign gate_aw = 1'b1;
   assign gate_w  = 1'b1;
   assign gate_r  = 1'b1;
   assign gate_b  = 1'b1;
`endif

   // ------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------
   rd_state_t         r_state_q, r_state_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [MEM_AW-1:0] rd_idx_q, rd_idx_d;
   logic [7:0]        rd_len_q, rd_len_d;
   logic [7:0]        rd_cnt_q, rd_cnt_d;
   logic              rd_fixed_q, rd_fixed_d;
   logic              rd_err_q, rd_err_d;
   logic              rvalid_hold_q, rvalid_hold_d;
   logic [MEM_AW-1:0] rd_step;
   logic              ar_hs;
   logic              r_hs;

   // Once rvalid is shown it must stay up until the master takes the beat,
   // so a stalled beat is remembered in rvalid_hold_q.
   assign arready = (r_state_q == R_IDLE) & gate_ar;
   assign rvalid  = (r_state_q == R_DATA) & (rvalid_hold_q | gate_r);
   assign rlast   = (r_state_q == R_DATA) & (rd_cnt_q == rd_len_q);
   assign rresp   = ((r_state_q == R_DATA) && rd_err_q) ? RESP_SLVERR : RESP_OKAY;
   assign rid     = rid_q;
   assign rdata   = ((r_state_q == R_DATA) && !rd_err_q) ? mem_q[rd_idx_q] : 32'h0;

   assign ar_hs   = arvalid & arready;
   assign r_hs    = rvalid & rready;
   assign rd_step = {{(MEM_AW-1){1'b0}}, ~rd_fixed_q};

   // Read FSM next state: latch the request, then step through the beats.
   // The word index wraps inside the array; the range flag comes from the
   // start address only.
   always_comb begin
      r_state_d     = r_state_q;
      rid_d         = rid_q;
      rd_idx_d      = rd_idx_q;
      rd_len_d      = rd_len_q;
      rd_cnt_d      = rd_cnt_q;
      rd_fixed_d    = rd_fixed_q;
      rd_err_d      = rd_err_q;
      rvalid_hold_d = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               rid_d      = arid;
               rd_idx_d   = araddr[MEM_AW+1:2];
               rd_err_d   = |araddr[31:MEM_AW+2];
               rd_len_d   = arlen;
               rd_fixed_d = (arburst == BURST_FIXED);
               rd_cnt_d   = 8'd0;
               r_state_d  = R_DATA;
            end
         end
         R_DATA: begin
            rvalid_hold_d = rvalid & ~rready;
            if (r_hs) begin
               if (rlast) begin
                  r_state_d = R_IDLE;
               end else begin
                  rd_cnt_d = rd_cnt_q + 8'd1;
                  rd_idx_d = rd_idx_q + rd_step;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read FSM registers; reset drops any burst in flight without a response.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state_q     <= R_IDLE;
         rid_q         <= '0;
         rd_idx_q      <= '0;
         rd_len_q      <= 8'd0;
         rd_cnt_q      <= 8'd0;
         rd_fixed_q    <= 1'b0;
         rd_err_q      <= 1'b0;
         rvalid_hold_q <= 1'b0;
      end else begin
         r_state_q     <= r_state_d;
         rid_q         <= rid_d;
         rd_idx_q      <= rd_idx_d;
         rd_len_q      <= rd_len_d;
         rd_cnt_q      <= rd_cnt_d;
         rd_fixed_q    <= rd_fixed_d;
         rd_err_q      <= rd_err_d;
         rvalid_hold_q <= rvalid_hold_d;
      end
   end

   // ------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------
   wr_state_t         w_state_q, w_state_d;
   logic [ID_W-1:0]   bid_q, bid_d;
   logic [MEM_AW-1:0] wr_idx_q, wr_idx_d;
   logic [7:0]        wr_len_q, wr_len_d;
   logic [7:0]        wr_cnt_q, wr_cnt_d;
   logic              wr_fixed_q, wr_fixed_d;
   logic              wr_range_err_q, wr_range_err_d;
   logic              wr_err_q, wr_err_d;
   logic              bvalid_hold_q, bvalid_hold_d;
   logic [MEM_AW-1:0] wr_step;
   logic              aw_hs;
   logic              w_hs;
   logic              b_hs;
   logic              mem_we;

   assign awready = (w_state_q == W_IDLE) & gate_aw;
   assign wready  = (w_state_q == W_DATA) & gate_w;
   assign bvalid  = (w_state_q == W_RESP) & (bvalid_hold_q | gate_b);
   assign bid     = bid_q;
   assign bresp   = ((w_state_q == W_RESP) && (wr_range_err_q || wr_err_q)) ?
                    RESP_SLVERR : RESP_OKAY;

   assign aw_hs   = awvalid & awready;
   assign w_hs    = wvalid & wready;
   assign b_hs    = bvalid & bready;
   assign wr_step = {{(MEM_AW-1){1'b0}}, ~wr_fixed_q};
   assign mem_we  = w_hs & ~wr_range_err_q & ~areset;

   // Write FSM next state: accept the address, absorb data beats until wlast,
   // flag any disagreement between wlast and the announced length, respond.
   always_comb begin
      w_state_d      = w_state_q;
      bid_d          = bid_q;
      wr_idx_d       = wr_idx_q;
      wr_len_d       = wr_len_q;
      wr_cnt_d       = wr_cnt_q;
      wr_fixed_d     = wr_fixed_q;
      wr_range_err_d = wr_range_err_q;
      wr_err_d       = wr_err_q;
      bvalid_hold_d  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               bid_d          = awid;
               wr_idx_d       = awaddr[MEM_AW+1:2];
               wr_range_err_d = |awaddr[31:MEM_AW+2];
               wr_len_d       = awlen;
               wr_fixed_d     = (awburst == BURST_FIXED);
               wr_cnt_d       = 8'd0;
               wr_err_d       = 1'b0;
               w_state_d      = W_DATA;
            end
         end
         W_DATA: begin
            if (w_hs) begin
               if (wlast != (wr_cnt_q == wr_len_q)) begin
                  wr_err_d = 1'b1;
               end
               wr_cnt_d = wr_cnt_q + 8'd1;
               wr_idx_d = wr_idx_q + wr_step;
               if (wlast) begin
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            bvalid_hold_d = bvalid & ~bready;
            if (b_hs) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Write FSM registers; reset abandons the burst and suppresses its response.
   always_ff @(posedge aclk) begin
      if (areset) begin
         w_state_q      <= W_IDLE;
         bid_q          <= '0;
         wr_idx_q       <= '0;
         wr_len_q       <= 8'd0;
         wr_cnt_q       <= 8'd0;
         wr_fixed_q     <= 1'b0;
         wr_range_err_q <= 1'b0;
         wr_err_q       <= 1'b0;
         bvalid_hold_q  <= 1'b0;
      end else begin
         w_state_q      <= w_state_d;
         bid_q          <= bid_d;
         wr_idx_q       <= wr_idx_d;
         wr_len_q       <= wr_len_d;
         wr_cnt_q       <= wr_cnt_d;
         wr_fixed_q     <= wr_fixed_d;
         wr_range_err_q <= wr_range_err_d;
         wr_err_q       <= wr_err_d;
         bvalid_hold_q  <= bvalid_hold_d;
      end
   end

   // Byte-masked memory write; contents survive reset by design.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem_q[wr_idx_q][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: self-checking bench for axi_sram_slave. A behavioural
// model (word array plus a queue of expected read beats and a simple write
// burst record) is compared against the DUT on every falling clock edge.
// Directed transactions pin the model with literal values, then random
// concurrent read/write traffic runs against it.

module tb_axi_sram_slave;

   localparam int MEM_AW  = 10;
   localparam int ID_W    = 4;
   localparam int DEPTH   = 1 << MEM_AW;
   localparam int TIMEOUT = 2000;

   logic            aclk;
   logic            areset;
   logic [ID_W-1:0] arid;
   logic [31:0]     araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic            arvalid;
   logic            arready;
   logic [ID_W-1:0] rid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;
   logic [ID_W-1:0] awid;
   logic [31:0]     awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            awvalid;
   logic            awready;
   logic [ID_W-1:0] wid;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;
   logic [ID_W-1:0] bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;

   int checks = 0;
   int errors = 0;

   axi_sram_slave #(.MEM_AW(MEM_AW), .ID_W(ID_W)) dut (
      .aclk(aclk), .areset(areset),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   // Free-running 100 MHz clock.
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Hard stop in case a wait loop is ever left unbounded.
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL timeout_%s: no handshake within %0d cycles", name, TIMEOUT);
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   typedef struct {
      logic [ID_W-1:0] id;
      int              idx;
      bit              err;
      bit              last;
   } rbeat_t;

   logic [31:0]     mem_m [DEPTH];
   rbeat_t          rq[$];
   int              w_stage = 0;   // 0 waiting for AW, 1 taking data, 2 responding
   logic [ID_W-1:0] w_id;
   int              w_idx;
   int              w_len;
   int              w_cnt;
   bit              w_rerr;
   bit              w_err;
   bit              w_fixed;
   bit              prev_reset = 1'b0;
   bit              prev_r_stall = 1'b0;
   bit              prev_b_stall = 1'b0;

   // Compare DUT against the model on every falling edge, then fold in the
   // handshakes that the coming rising edge will complete.
   always @(negedge aclk) begin
      rbeat_t exp_b;
      if (prev_reset) begin
         checkOutput("rst_rvalid", rvalid, 0);
         checkOutput("rst_rlast", rlast, 0);
         checkOutput("rst_wready", wready, 0);
         checkOutput("rst_bvalid", bvalid, 0);
         checkOutput("rst_rid", rid, 0);
         checkOutput("rst_bid", bid, 0);
         checkOutput("rst_rresp", rresp, 0);
         checkOutput("rst_bresp", bresp, 0);
      end
`ifdef AXI_SLV_DELAY_EN
      checkOutput("arready_busy", arready && rq.size() != 0, 0);
      checkOutput("awready_busy", awready && w_stage != 0, 0);
      checkOutput("bvalid_early", bvalid && w_stage != 2, 0);
      if (prev_r_stall && !prev_reset) checkOutput("rvalid_hold", rvalid, 1);
      if (prev_b_stall && !prev_reset) checkOutput("bvalid_hold", bvalid, 1);
`else
      checkOutput("arready", arready, rq.size() == 0);
      checkOutput("rvalid", rvalid, rq.size() != 0);
      checkOutput("awready", awready, w_stage == 0);
      checkOutput("wready", wready, w_stage == 1);
      checkOutput("bvalid", bvalid, w_stage == 2);
`endif
      checkOutput("wready_before_aw", wready && w_stage != 1, 0);
      if (rvalid) begin
         if (rq.size() == 0) begin
            checkOutput("rvalid_unexpected", rvalid, 0);
         end else begin
            exp_b = rq[0];
            checkOutput("rid", rid, exp_b.id);
            checkOutput("rdata", rdata, exp_b.err ? 32'h0 : mem_m[exp_b.idx]);
            checkOutput("rresp", rresp, exp_b.err ? 2'b10 : 2'b00);
            checkOutput("rlast", rlast, exp_b.last);
         end
      end
      if (bvalid && w_stage == 2) begin
         checkOutput("bid", bid, w_id);
         checkOutput("bresp", bresp, (w_rerr || w_err) ? 2'b10 : 2'b00);
      end

      if (areset) begin
         rq.delete();
         w_stage = 0;
      end else begin
         if (rvalid && rready && rq.size() != 0) void'(rq.pop_front());
         if (arvalid && arready) begin
            for (int b = 0; b <= int'(arlen); b++) begin
               exp_b.id   = arid;
               exp_b.err  = (araddr[31:MEM_AW+2] != 0);
               exp_b.idx  = (arburst == 2'b00) ? int'(araddr[MEM_AW+1:2])
                                               : (int'(araddr[MEM_AW+1:2]) + b) % DEPTH;
               exp_b.last = (b == int'(arlen));
               rq.push_back(exp_b);
            end
         end
         if (awvalid && awready) begin
            w_id    = awid;
            w_idx   = int'(awaddr[MEM_AW+1:2]);
            w_rerr  = (awaddr[31:MEM_AW+2] != 0);
            w_len   = int'(awlen);
            w_cnt   = 0;
            w_err   = 1'b0;
            w_fixed = (awburst == 2'b00);
            w_stage = 1;
         end
         if (wvalid && wready && w_stage == 1) begin
            if (!w_rerr) begin
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) mem_m[w_idx][8*b +: 8] = wdata[8*b +: 8];
            end
            if (wlast != (w_cnt == w_len)) w_err = 1'b1;
            w_cnt++;
            if (!w_fixed) w_idx = (w_idx + 1) % DEPTH;
            if (wlast) w_stage = 2;
         end
         if (bvalid && bready && w_stage == 2) w_stage = 0;
      end
      prev_r_stall = rvalid && !rready && !areset;
      prev_b_stall = bvalid && !bready && !areset;
      prev_reset   = areset;
   end

   // ------------------------------------------------------------------
   // Master-side transaction tasks (start and end at posedge + #1)
   // ------------------------------------------------------------------
   logic [31:0]     rcap_data [8];
   logic [1:0]      rcap_resp [8];
   logic            rcap_last [8];
   logic [ID_W-1:0] rcap_id;
   int              rd_first_lat;
   logic [31:0]     wbuf_data [8];
   logic [3:0]      wbuf_strb [8];
   logic [1:0]      bcap_resp;
   logic [ID_W-1:0] bcap_id;

   task automatic axiRead(input logic [ID_W-1:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] burst,
                          input int stall_pct, input int hold_off, input int max_beats);
      int n;
      int beat;
      arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'b010;
      arvalid = 1'b1;
      n = 0;
      forever begin
         @(negedge aclk);
         if (arready) break;
         n++;
         if (n >= TIMEOUT) begin reportTimeout("ar"); break; end
      end
      @(posedge aclk); #1;
      arvalid = 1'b0;
      beat = 0;
      n = 0;
      rd_first_lat = -1;
      while (beat < max_beats && n < TIMEOUT) begin
         rready = (n < hold_off) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
         @(negedge aclk);
         if (rvalid && rready) begin
            if (beat == 0) rd_first_lat = n;
            rcap_data[beat] = rdata;
            rcap_resp[beat] = rresp;
            rcap_last[beat] = rlast;
            rcap_id = rid;
            beat++;
         end
         @(posedge aclk); #1;
         n++;
      end
      rready = 1'b0;
      if (beat < max_beats) reportTimeout("r");
   endtask

   task automatic axiWrite(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input int nbeats, input int stall_pct);
      int n;
      int beat;
      awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'b010;
      awvalid = 1'b1;
      n = 0;
      forever begin
         @(negedge aclk);
         if (awready) break;
         n++;
         if (n >= TIMEOUT) begin reportTimeout("aw"); break; end
      end
      @(posedge aclk); #1;
      awvalid = 1'b0;
      beat = 0;
      n = 0;
      while (beat < nbeats && n < TIMEOUT) begin
         wvalid = ($urandom_range(0, 99) >= stall_pct);
         wid    = id;
         wdata  = wbuf_data[beat];
         wstrb  = wbuf_strb[beat];
         wlast  = (beat == nbeats - 1);
         @(negedge aclk);
         if (wvalid && wready) beat++;
         @(posedge aclk); #1;
         n++;
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
      if (beat < nbeats) reportTimeout("w");
      n = 0;
      forever begin
         bready = ($urandom_range(0, 99) >= stall_pct);
         @(negedge aclk);
         if (bvalid && bready) begin
            bcap_resp = bresp;
            bcap_id   = bid;
            @(posedge aclk); #1;
            break;
         end
         @(posedge aclk); #1;
         n++;
         if (n >= TIMEOUT) begin reportTimeout("b"); break; end
      end
      bready = 1'b0;
   endtask

   // Random concurrent traffic: independent read and write streams, with
   // occasional out-of-range addresses and mis-placed wlast.
   task automatic applyStimulus(input int count);
      fork
         begin
            for (int i = 0; i < count; i++) begin
               logic [31:0] a;
               logic [7:0]  l;
               a = ($urandom_range(0, 9) == 0) ? {4'($urandom_range(1, 15)), 28'($urandom)}
                                               : 32'($urandom_range(0, DEPTH - 1) * 4);
               l = ($urandom_range(0, 1) == 1) ? 8'd3 : 8'd0;
               axiRead(4'($urandom), a, l, 2'($urandom_range(0, 2)), 30, 0, int'(l) + 1);
            end
         end
         begin
            for (int i = 0; i < count; i++) begin
               logic [31:0] a;
               logic [7:0]  l;
               int          nb;
               a = ($urandom_range(0, 9) == 0) ? {4'($urandom_range(1, 15)), 28'($urandom)}
                                               : 32'($urandom_range(0, DEPTH - 1) * 4);
               l = ($urandom_range(0, 1) == 1) ? 8'd3 : 8'd0;
               nb = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 5) : int'(l) + 1;
               for (int k = 0; k < 8; k++) begin
                  wbuf_data[k] = $urandom;
                  wbuf_strb[k] = 4'($urandom);
               end
               axiWrite(4'($urandom), a, l, 2'($urandom_range(0, 2)), nb, 30);
            end
         end
      join
   endtask

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      areset = 1'b1;
      arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
      rready = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
      wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;

      repeat (3) @(posedge aclk);
      @(negedge aclk);
`ifndef AXI_SLV_DELAY_EN
      checkOutput("reset_arready", arready, 1);
      checkOutput("reset_awready", awready, 1);
`endif
      checkOutput("reset_rvalid", rvalid, 0);
      checkOutput("reset_bvalid", bvalid, 0);
      @(posedge aclk); #1;
      areset = 1'b0;

      // Fill the whole array with a recognisable pattern C0DE0000 | index.
      for (int i = 0; i < DEPTH; i += 4) begin
         for (int k = 0; k < 4; k++) begin
            wbuf_data[k] = 32'hC0DE0000 | 32'(i + k);
            wbuf_strb[k] = 4'hF;
         end
         axiWrite('0, 32'(i * 4), 8'd3, 2'b01, 4, 0);
      end

      // Single read of a freshly written word.
      wbuf_data[0] = 32'hDEADBEEF; wbuf_strb[0] = 4'hF;
      axiWrite(4'd2, 32'h14, 8'd0, 2'b01, 1, 0);
      checkOutput("single_wr_bresp", bcap_resp, 2'b00);
      axiRead(4'd1, 32'h14, 8'd0, 2'b01, 0, 0, 1);
      checkOutput("single_rdata", rcap_data[0], 32'hDEADBEEF);
      checkOutput("single_rresp", rcap_resp[0], 2'b00);
      checkOutput("single_rlast", rcap_last[0], 1);
      checkOutput("single_rid", rcap_id, 4'd1);
`ifndef AXI_SLV_DELAY_EN
      checkOutput("single_latency", rd_first_lat, 0);
      @(negedge aclk);
      checkOutput("single_arready_t2", arready, 1);
      @(posedge aclk); #1;
`endif

      // Four-beat INCR read with two stall cycles up front.
      axiRead(4'd2, 32'h40, 8'd3, 2'b01, 0, 2, 4);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("burst_rdata%0d", k), rcap_data[k], 32'hC0DE0010 + 32'(k));
         checkOutput($sformatf("burst_rlast%0d", k), rcap_last[k], k == 3);
      end

      // Four-beat write with a partial strobe on beat 1.
      wbuf_data[0] = 32'h11111111; wbuf_strb[0] = 4'hF;
      wbuf_data[1] = 32'h22222222; wbuf_strb[1] = 4'h1;
      wbuf_data[2] = 32'h33333333; wbuf_strb[2] = 4'hF;
      wbuf_data[3] = 32'h44444444; wbuf_strb[3] = 4'hF;
      axiWrite(4'd5, 32'h80, 8'd3, 2'b01, 4, 30);
      checkOutput("burst_bresp", bcap_resp, 2'b00);
      checkOutput("burst_bid", bcap_id, 4'd5);
      axiRead(4'd0, 32'h80, 8'd3, 2'b01, 0, 0, 4);
      checkOutput("strb_rd0", rcap_data[0], 32'h11111111);
      checkOutput("strb_rd1", rcap_data[1], 32'hC0DE0022);
      checkOutput("strb_rd2", rcap_data[2], 32'h33333333);
      checkOutput("strb_rd3", rcap_data[3], 32'h44444444);

      // Out-of-range read and write; word 0 must not change.
      axiRead(4'd7, 32'h1000_0000, 8'd0, 2'b01, 0, 0, 1);
      checkOutput("oor_rdata", rcap_data[0], 32'h0);
      checkOutput("oor_rresp", rcap_resp[0], 2'b10);
      wbuf_data[0] = 32'h12345678; wbuf_strb[0] = 4'hF;
      axiWrite(4'd7, 32'h1000_0000, 8'd0, 2'b01, 1, 0);
      checkOutput("oor_bresp", bcap_resp, 2'b10);
      axiRead(4'd0, 32'h0, 8'd0, 2'b01, 0, 0, 1);
      checkOutput("oor_mem_kept", rcap_data[0], 32'hC0DE0000);

      // Early wlast on a write while a read is issued in the same cycle.
      wbuf_data[0] = 32'hAAAA0001; wbuf_strb[0] = 4'hF;
      wbuf_data[1] = 32'hAAAA0002; wbuf_strb[1] = 4'hF;
      fork
         axiWrite(4'd3, 32'h100, 8'd3, 2'b01, 2, 0);
         axiRead(4'd4, 32'h200, 8'd3, 2'b01, 0, 0, 4);
      join
      checkOutput("early_bresp", bcap_resp, 2'b10);
      checkOutput("early_bid", bcap_id, 4'd3);
      checkOutput("conc_rid", rcap_id, 4'd4);
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("conc_rdata%0d", k), rcap_data[k], 32'hC0DE0080 + 32'(k));
      axiRead(4'd0, 32'h100, 8'd3, 2'b01, 0, 0, 4);
      checkOutput("early_rd0", rcap_data[0], 32'hAAAA0001);
      checkOutput("early_rd1", rcap_data[1], 32'hAAAA0002);
      checkOutput("early_rd2", rcap_data[2], 32'hC0DE0042);
      checkOutput("early_rd3", rcap_data[3], 32'hC0DE0043);

      // Burst crossing the top of memory wraps to index 0; FIXED repeats.
      axiRead(4'd9, 32'hFF8, 8'd3, 2'b01, 0, 0, 4);
      checkOutput("wrap_rd0", rcap_data[0], 32'hC0DE03FE);
      checkOutput("wrap_rd1", rcap_data[1], 32'hC0DE03FF);
      checkOutput("wrap_rd2", rcap_data[2], 32'hC0DE0000);
      checkOutput("wrap_rd3", rcap_data[3], 32'hC0DE0001);
      axiRead(4'd9, 32'h28, 8'd3, 2'b00, 0, 0, 4);
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("fixed_rd%0d", k), rcap_data[k], 32'hC0DE000A);

      // Reset in the middle of a read burst, then a clean read.
      axiRead(4'd6, 32'h40, 8'd3, 2'b01, 0, 0, 2);
      checkOutput("pre_reset_rd1", rcap_data[1], 32'hC0DE0011);
      areset = 1'b1;
      @(posedge aclk); #1;
      areset = 1'b0;
      @(negedge aclk);
      checkOutput("midrst_rvalid", rvalid, 0);
`ifndef AXI_SLV_DELAY_EN
      checkOutput("midrst_arready", arready, 1);
`endif
      @(posedge aclk); #1;
      axiRead(4'd8, 32'h14, 8'd0, 2'b01, 0, 0, 1);
      checkOutput("post_reset_rdata", rcap_data[0], 32'hDEADBEEF);
      checkOutput("post_reset_rid", rcap_id, 4'd8);

      applyStimulus(60);

      repeat (4) @(posedge aclk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
